rgmii_rx_decoder: RTL and testbench

RGMII_RX_DECODER -- requirements
Module: rgmii_rx_decoder

---
 rtl/rgmii_rx_decoder.sv | 193 +++++++++++++++++++
 tb/tb_rgmii_rx_decoder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/rgmii_rx_decoder.sv
// RGMII receive decoder: turns IDDR rising/falling samples into a byte stream with last/error flags.
// Optional errored-frame counter on rx_err_cnt is built only when RX_ERR_CNT_EN is defined.
module rgmii_rx_decoder #(
    parameter int unsigned DATA_WIDTH    = 4,
    parameter int unsigned ERR_CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      link_1g,
    input  logic [DATA_WIDTH:0]       q1,
    input  logic [DATA_WIDTH:0]       q2,
    output logic [2*DATA_WIDTH-1:0]   m_rx_data,
    output logic                      m_rx_valid,
    output logic                      m_rx_last,
    output logic                      m_rx_user
`ifdef RX_ERR_CNT_EN
    ,
    output logic [ERR_CNT_WIDTH-1:0]  rx_err_cnt
`endif
);

    localparam int unsigned BYTE_W = 2 * DATA_WIDTH;

    if (ERR_CNT_WIDTH == 0) begin : g_bad_cfg
        $error("ERR_CNT_WIDTH must be at least 1");
    end

    typedef enum logic [1:0] {
        S_DROP  = 2'd0,
        S_IDLE  = 2'd1,
        S_FRAME = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic                   mode_1g_q, mode_1g_d;
    logic                   phase_q, phase_d;
    logic [DATA_WIDTH-1:0]  nib_q, nib_d;
    logic [BYTE_W-1:0]      hold_q, hold_d;
    logic                   hold_full_q, hold_full_d;
    logic                   err_seen_q, err_seen_d;
    logic [BYTE_W-1:0]      data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   last_q, last_d;
    logic                   user_q, user_d;

    logic                   dv_c;
    logic                   er_c;
    logic [BYTE_W-1:0]      byte_1g_c;
    logic [BYTE_W-1:0]      byte_nib_c;
    logic                   frame_end_c;
    logic                   frame_bad_c;

    assign dv_c        = q1[DATA_WIDTH];
    assign er_c        = q1[DATA_WIDTH] ^ q2[DATA_WIDTH];
    assign byte_1g_c   = {q2[DATA_WIDTH-1:0], q1[DATA_WIDTH-1:0]};
    assign byte_nib_c  = {q1[DATA_WIDTH-1:0], nib_q};
    assign frame_end_c = (state_q == S_FRAME) && !dv_c;
    // A pending low nibble at end of frame means a truncated byte.
    assign frame_bad_c = err_seen_q | er_c | (~mode_1g_q & phase_q);

    always_comb begin
        state_d     = state_q;
        mode_1g_d   = mode_1g_q;
        phase_d     = phase_q;
        nib_d       = nib_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        err_seen_d  = err_seen_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        last_d      = 1'b0;
        user_d      = 1'b0;

        case (state_q)
            S_DROP: begin
                if (!dv_c) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                hold_full_d = 1'b0;
                phase_d     = 1'b0;
                if (dv_c) begin
                    state_d    = S_FRAME;
                    mode_1g_d  = link_1g;
                    err_seen_d = er_c;
                    if (link_1g) begin
                        hold_d      = byte_1g_c;
                        hold_full_d = 1'b1;
                    end else begin
                        nib_d   = q1[DATA_WIDTH-1:0];
                        phase_d = 1'b1;
                    end
                end
            end
            S_FRAME: begin
                err_seen_d = err_seen_q | er_c;
                if (dv_c) begin
                    if (!mode_1g_q) begin
                        phase_d = ~phase_q;
                        if (!phase_q) begin
                            nib_d = q1[DATA_WIDTH-1:0];
                        end
                    end
                    // A byte completes every 1G cycle, or on the high nibble in 10/100.
                    if (mode_1g_q || phase_q) begin
                        if (hold_full_q) begin
                            valid_d = 1'b1;
                            data_d  = hold_q;
                        end
                        hold_d      = mode_1g_q ? byte_1g_c : byte_nib_c;
                        hold_full_d = 1'b1;
                    end
                end else begin
                    state_d     = S_IDLE;
                    hold_full_d = 1'b0;
                    phase_d     = 1'b0;
                    if (hold_full_q) begin
                        valid_d = 1'b1;
                        last_d  = 1'b1;
                        user_d  = frame_bad_c;
                        data_d  = hold_q;
                    end
                end
            end
            default: begin
                state_d = S_DROP;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_DROP;
            mode_1g_q   <= 1'b0;
            phase_q     <= 1'b0;
            nib_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            err_seen_q  <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            user_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_1g_q   <= mode_1g_d;
            phase_q     <= phase_d;
            nib_q       <= nib_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            err_seen_q  <= err_seen_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            user_q      <= user_d;
        end
    end

    assign m_rx_data  = data_q;
    assign m_rx_valid = valid_q;
    assign m_rx_last  = last_q;
    assign m_rx_user  = user_q;

`ifdef RX_ERR_CNT_EN
    logic                     err_end_c;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

    // Errored frame: last beat flagged bad, or frame ended with nothing to emit.
    assign err_end_c = frame_end_c & (frame_bad_c | ~hold_full_q);

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_end_c && (err_cnt_q != {ERR_CNT_WIDTH{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign rx_err_cnt = err_cnt_q;
`else
    logic unused_end_c;
    assign unused_end_c = frame_end_c;
`endif

endmodule

// File: tb/tb_rgmii_rx_decoder.sv
// Scoreboard bench for rgmii_rx_decoder: directed frames push expected beats, a monitor pops and compares.
module tb_rgmii_rx_decoder;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       link_1g;
    logic [4:0] q1;
    logic [4:0] q2;
    logic [7:0] m_rx_data;
    logic       m_rx_valid;
    logic       m_rx_last;
    logic       m_rx_user;
`ifdef RX_ERR_CNT_EN
    logic [15:0] rx_err_cnt;
`endif

    rgmii_rx_decoder #(.DATA_WIDTH(4), .ERR_CNT_WIDTH(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .link_1g    (link_1g),
        .q1         (q1),
        .q2         (q2),
        .m_rx_data  (m_rx_data),
        .m_rx_valid (m_rx_valid),
        .m_rx_last  (m_rx_last),
        .m_rx_user  (m_rx_user)
`ifdef RX_ERR_CNT_EN
        ,
        .rx_err_cnt (rx_err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       user;
        int         cyc;
    } beat_t;

    beat_t exp_q[$];
    int    n_chk  = 0;
    int    n_fail = 0;
    int    cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic l, input logic u, input int c);
        beat_t b;
        b.data = d; b.last = l; b.user = u; b.cyc = c;
        exp_q.push_back(b);
    endtask

    // Monitor: every visible beat must match the head of the scoreboard.
    always @(posedge clk) begin
        #1;
        if (m_rx_valid === 1'b1) begin
            chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                beat_t e;
                e = exp_q.pop_front();
                chk("beat_data", 32'(m_rx_data), 32'(e.data));
                chk("beat_last", 32'(m_rx_last), 32'(e.last));
                chk("beat_user", 32'(m_rx_user), 32'(e.user));
                if (e.cyc >= 0) chk("beat_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic drive(input logic l, input logic [4:0] a, input logic [4:0] b);
        link_1g = l; q1 = a; q2 = b;
        @(negedge clk);
    endtask

    task automatic b1g(input logic l, input logic [7:0] d, input logic err);
        drive(l, {1'b1, d[3:0]}, {~err, d[7:4]});
    endtask

    task automatic nib(input logic l, input logic [3:0] n);
        drive(l, {1'b1, n}, 5'b1_0000);
    endtask

    task automatic gap(input logic l);
        drive(l, 5'd0, 5'd0);
    endtask

    task automatic chk_cnt(input string name, input int exp);
`ifdef RX_ERR_CNT_EN
        chk(name, 32'(rx_err_cnt), 32'(exp));
`else
        if (exp < 0) $display("unused %s", name);
`endif
    endtask

    initial begin
        int c0;
        reset_n = 1'b0; link_1g = 1'b1; q1 = '0; q2 = '0;
        repeat (3) @(negedge clk);
        chk("rst_data",  32'(m_rx_data),  32'd0);
        chk("rst_valid", 32'(m_rx_valid), 32'd0);
        chk("rst_last",  32'(m_rx_last),  32'd0);
        chk("rst_user",  32'(m_rx_user),  32'd0);
        chk_cnt("rst_cnt", 0);
        reset_n = 1'b1;
        gap(1); gap(1);

        // 1G preamble-like bytes, exact latency checked
        c0 = cyc;
        push(8'h55, 1'b0, 1'b0, c0 + 2);
        push(8'hD5, 1'b0, 1'b0, c0 + 3);
        push(8'h12, 1'b0, 1'b0, c0 + 4);
        push(8'h34, 1'b1, 1'b0, c0 + 5);
        b1g(1, 8'h55, 0); b1g(1, 8'hD5, 0); b1g(1, 8'h12, 0); b1g(1, 8'h34, 0);
        gap(1); gap(1);

        // 10/100 nibbles, low nibble first
        push(8'h55, 1'b0, 1'b0, -1);
        push(8'hD5, 1'b0, 1'b0, -1);
        push(8'h12, 1'b1, 1'b0, -1);
        nib(0, 4'h5); nib(0, 4'h5); nib(0, 4'h5); nib(0, 4'hD); nib(0, 4'h2); nib(0, 4'h1);
        gap(0); gap(0);
        chk_cnt("cnt_after_good", 0);

        // 1G with er on the 2nd byte
        push(8'hA1, 1'b0, 1'b0, -1);
        push(8'hB2, 1'b0, 1'b0, -1);
        push(8'hC3, 1'b1, 1'b1, -1);
        b1g(1, 8'hA1, 0); b1g(1, 8'hB2, 1); b1g(1, 8'hC3, 0);
        gap(1); gap(1);
        chk_cnt("cnt_after_er", 1);

        // 10/100 odd nibble count: trailing nibble dropped, frame flagged
        push(8'hBA, 1'b1, 1'b1, -1);
        nib(0, 4'hA); nib(0, 4'hB); nib(0, 4'hC);
        gap(0); gap(0);
        chk_cnt("cnt_after_odd", 2);

        // Reset mid-frame with dv held high
        push(8'h11, 1'b0, 1'b0, -1);
        b1g(1, 8'h11, 0); b1g(1, 8'h22, 0);
        reset_n = 1'b0;
        b1g(1, 8'h33, 0);
        chk("midrst_valid", 32'(m_rx_valid), 32'd0);
        chk("midrst_data",  32'(m_rx_data),  32'd0);
        reset_n = 1'b1;
        b1g(1, 8'h44, 0); b1g(1, 8'h55, 0);
        gap(1); gap(1);
        chk_cnt("cnt_after_rst", 0);
        push(8'h66, 1'b0, 1'b0, -1);
        push(8'h77, 1'b1, 1'b0, -1);
        b1g(1, 8'h66, 0); b1g(1, 8'h77, 0);
        gap(1); gap(1);

        // link_1g toggled mid-frame is ignored; false carrier in IDLE is silent
        push(8'h12, 1'b0, 1'b0, -1);
        push(8'h34, 1'b0, 1'b0, -1);
        push(8'h56, 1'b1, 1'b0, -1);
        b1g(1, 8'h12, 0); b1g(0, 8'h34, 0); b1g(0, 8'h56, 0);
        gap(0);
        drive(1, 5'b0_0000, 5'b1_0000); drive(1, 5'b0_0000, 5'b1_1111);
        gap(1);
        push(8'h87, 1'b0, 1'b0, -1);
        push(8'hA9, 1'b1, 1'b0, -1);
        nib(0, 4'h7); nib(1, 4'h8); nib(1, 4'h9); nib(1, 4'hA);
        gap(1); gap(1);
        chk_cnt("cnt_after_toggle", 0);

        // Lone nibble: no beat, but counted as errored
        nib(0, 4'h3);
        gap(0); gap(0);
        chk_cnt("cnt_after_lone", 1);

        // Frame right after a last beat (one-cycle gap)
        push(8'hE1, 1'b1, 1'b0, -1);
        b1g(1, 8'hE1, 0);
        gap(1);
        push(8'hF2, 1'b1, 1'b0, -1);
        b1g(1, 8'hF2, 0);
        gap(1);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
